// File: rtl/alu_issue_wb.sv
// Sequencer around the 16-bit ALU: reads operands, issues one op, writes result and flags back.
// Latency: accept at edge N, alu_enable in the cycle after, wb_valid pulse two cycles after that.
// Backpressure: in_ready only in IDLE, so one instruction per 3 cycles; accepted work is never dropped.
module alu_issue_wb #(
   parameter int NREGS   = 8,
   parameter int NUM_OPS = 12,
   parameter int RZERO   = 1,
   localparam int RA     = $clog2(NREGS)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [3:0]    in_op,
   input  logic [RA-1:0] in_rd,
   input  logic [RA-1:0] in_rs1,
   input  logic [RA-1:0] in_rs2,
   input  logic          in_imm_en,
   input  logic [15:0]   in_imm,
   output logic          alu_enable,
   output logic [15:0]   alu_a,
   output logic [15:0]   alu_b,
   output logic [3:0]    alu_op,
   input  logic [15:0]   alu_result,
   input  logic          alu_zero,
   input  logic          alu_carry,
   input  logic          alu_ovf,
   output logic          wb_valid,
   output logic [RA-1:0] wb_rd,
   output logic [15:0]   wb_data,
   output logic [2:0]    flags,
   output logic          err_illegal,
   input  logic [RA-1:0] dbg_addr,
   output logic [15:0]   dbg_data
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ISSUE   = 2'd1,
      S_CAPTURE = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [15:0]   regs_q [NREGS];
   logic [15:0]   alu_a_q, alu_b_q;
   logic [3:0]    alu_op_q;
   logic [RA-1:0] rd_q;
   logic          wb_valid_q;
   logic [RA-1:0] wb_rd_q;
   logic [15:0]   wb_data_q;
   logic [2:0]    flags_q;
   logic          err_q;

   logic          accept;
   logic          op_legal;
   logic [15:0]   rs1_val, rs2_val;
   logic          rd_write_en;

   assign in_ready = (state_q == S_IDLE) && !reset;
   assign accept   = in_valid && in_ready;
   assign op_legal = int'(in_op) < NUM_OPS;

   // r0 reads as zero when hardwired; writes to it are suppressed at capture time
   assign rs1_val     = ((RZERO != 0) && (in_rs1 == '0)) ? 16'h0000 : regs_q[in_rs1];
   assign rs2_val     = ((RZERO != 0) && (in_rs2 == '0)) ? 16'h0000 : regs_q[in_rs2];
   assign dbg_data    = ((RZERO != 0) && (dbg_addr == '0)) ? 16'h0000 : regs_q[dbg_addr];
   assign rd_write_en = !((RZERO != 0) && (rd_q == '0));

   assign alu_enable  = (state_q == S_ISSUE) && !reset;
   assign alu_a       = alu_a_q;
   assign alu_b       = alu_b_q;
   assign alu_op      = alu_op_q;
   assign wb_valid    = wb_valid_q;
   assign wb_rd       = wb_rd_q;
   assign wb_data     = wb_data_q;
   assign flags       = flags_q;
   assign err_illegal = err_q;

   // Sequencer state register
   always_ff @(posedge clk) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // Next state: illegal opcodes are absorbed in IDLE without touching the ALU
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:    if (accept && op_legal) state_d = S_ISSUE;
         S_ISSUE:   state_d = S_CAPTURE;
         S_CAPTURE: state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   // Operand latch at accept, result/flags writeback at the end of CAPTURE
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) regs_q[i] <= 16'h0000;
         alu_a_q    <= 16'h0000;
         alu_b_q    <= 16'h0000;
         alu_op_q   <= 4'h0;
         rd_q       <= '0;
         wb_valid_q <= 1'b0;
         wb_rd_q    <= '0;
         wb_data_q  <= 16'h0000;
         flags_q    <= 3'b000;
         err_q      <= 1'b0;
      end else begin
         wb_valid_q <= 1'b0;
         if (accept) begin
            alu_a_q  <= rs1_val;
            alu_b_q  <= in_imm_en ? in_imm : rs2_val;
            alu_op_q <= in_op;
            rd_q     <= in_rd;
            if (!op_legal) err_q <= 1'b1;
         end
         if (state_q == S_CAPTURE) begin
            if (rd_write_en) regs_q[rd_q] <= alu_result;
            flags_q    <= {alu_zero, alu_carry, alu_ovf};
            wb_valid_q <= 1'b1;
            wb_rd_q    <= rd_q;
            wb_data_q  <= alu_result;
         end
      end
   end

endmodule
